// File: rtl/dma_mem_arbiter.sv
// Two-master burst arbiter (M0 = CPU, M1 = DMA) onto one memory port. Read and write
// channels each run their own IDLE -> REQ -> DATA grant FSM with a round-robin pointer.
module dma_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  // master read request/data
  input  logic [2*ADDR_WIDTH-1:0] m_rd_req_addr,
  input  logic [9:0]              m_rd_req_len,
  input  logic [1:0]              m_rd_req_valid,
  output logic [1:0]              m_rd_req_ready,
  output logic [DATA_WIDTH-1:0]   m_rd_rdata,
  output logic [1:0]              m_rd_valid,
  output logic [1:0]              m_rd_last,
  input  logic [1:0]              m_rd_ready,
  // master write request/data
  input  logic [2*ADDR_WIDTH-1:0] m_wr_req_addr,
  input  logic [9:0]              m_wr_req_len,
  input  logic [1:0]              m_wr_req_valid,
  output logic [1:0]              m_wr_req_ready,
  input  logic [2*DATA_WIDTH-1:0] m_wr_data,
  input  logic [1:0]              m_wr_valid,
  input  logic [1:0]              m_wr_last,
  output logic [1:0]              m_wr_ready,
  // memory read side
  output logic [ADDR_WIDTH-1:0]   s_rd_req_addr,
  output logic [4:0]              s_rd_req_len,
  output logic                    s_rd_req_valid,
  input  logic                    s_rd_req_ready,
  input  logic [DATA_WIDTH-1:0]   s_rd_rdata,
  input  logic                    s_rd_last,
  input  logic                    s_rd_valid,
  output logic                    s_rd_ready,
  // memory write side
  output logic [ADDR_WIDTH-1:0]   s_wr_req_addr,
  output logic [4:0]              s_wr_req_len,
  output logic                    s_wr_req_valid,
  input  logic                    s_wr_req_ready,
  output logic [DATA_WIDTH-1:0]   s_wr_data,
  output logic                    s_wr_last,
  output logic                    s_wr_valid,
  input  logic                    s_wr_ready
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StData = 2'd2;

  logic [1:0] rd_state_q, rd_state_d, wr_state_q, wr_state_d;
  logic       rd_owner_q, rd_owner_d, wr_owner_q, wr_owner_d;
  logic       rd_rr_q, rd_rr_d, wr_rr_q, wr_rr_d;
  logic       rd_win, wr_win;

  // Tie-break: fixed priority favours M0, otherwise the round-robin pointer decides.
  always_comb begin
    if (&m_rd_req_valid) rd_win = (FIXED_PRIO != 0) ? 1'b0 : rd_rr_q;
    else                 rd_win = m_rd_req_valid[1];
    if (&m_wr_req_valid) wr_win = (FIXED_PRIO != 0) ? 1'b0 : wr_rr_q;
    else                 wr_win = m_wr_req_valid[1];
  end

  // Read channel routing
  always_comb begin
    s_rd_req_addr  = rd_owner_q ? m_rd_req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                : m_rd_req_addr[ADDR_WIDTH-1:0];
    s_rd_req_len   = rd_owner_q ? m_rd_req_len[9:5] : m_rd_req_len[4:0];
    s_rd_req_valid = (rd_state_q == StReq) && m_rd_req_valid[rd_owner_q];
    m_rd_req_ready = 2'b00;
    m_rd_valid     = 2'b00;
    m_rd_last      = 2'b00;
    s_rd_ready     = 1'b0;
    m_rd_rdata     = s_rd_rdata;
    if (rd_state_q == StReq) m_rd_req_ready[rd_owner_q] = s_rd_req_ready;
    if (rd_state_q == StData) begin
      m_rd_valid[rd_owner_q] = s_rd_valid;
      m_rd_last[rd_owner_q]  = s_rd_last;
      s_rd_ready             = m_rd_ready[rd_owner_q];
    end
  end

  // Write channel routing
  always_comb begin
    s_wr_req_addr  = wr_owner_q ? m_wr_req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                : m_wr_req_addr[ADDR_WIDTH-1:0];
    s_wr_req_len   = wr_owner_q ? m_wr_req_len[9:5] : m_wr_req_len[4:0];
    s_wr_req_valid = (wr_state_q == StReq) && m_wr_req_valid[wr_owner_q];
    s_wr_data      = wr_owner_q ? m_wr_data[2*DATA_WIDTH-1:DATA_WIDTH]
                                : m_wr_data[DATA_WIDTH-1:0];
    s_wr_valid     = (wr_state_q == StData) && m_wr_valid[wr_owner_q];
    s_wr_last      = (wr_state_q == StData) && m_wr_last[wr_owner_q];
    m_wr_req_ready = 2'b00;
    m_wr_ready     = 2'b00;
    if (wr_state_q == StReq)  m_wr_req_ready[wr_owner_q] = s_wr_req_ready;
    if (wr_state_q == StData) m_wr_ready[wr_owner_q]     = s_wr_ready;
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rd_owner_d = rd_owner_q;
    rd_rr_d    = rd_rr_q;
    unique case (rd_state_q)
      StIdle: if (|m_rd_req_valid) begin
        rd_owner_d = rd_win;
        rd_state_d = StReq;
      end
      StReq:  if (s_rd_req_valid && s_rd_req_ready) rd_state_d = StData;
      StData: if (s_rd_valid && s_rd_ready && s_rd_last) begin
        rd_rr_d    = ~rd_owner_q;
        rd_state_d = StIdle;
      end
      default: rd_state_d = StIdle;
    endcase
  end

  always_comb begin
    wr_state_d = wr_state_q;
    wr_owner_d = wr_owner_q;
    wr_rr_d    = wr_rr_q;
    unique case (wr_state_q)
      StIdle: if (|m_wr_req_valid) begin
        wr_owner_d = wr_win;
        wr_state_d = StReq;
      end
      StReq:  if (s_wr_req_valid && s_wr_req_ready) wr_state_d = StData;
      StData: if (s_wr_valid && s_wr_ready && s_wr_last) begin
        wr_rr_d    = ~wr_owner_q;
        wr_state_d = StIdle;
      end
      default: wr_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_q <= StIdle;
      rd_owner_q <= 1'b0;
      rd_rr_q    <= 1'b0;
      wr_state_q <= StIdle;
      wr_owner_q <= 1'b0;
      wr_rr_q    <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_owner_q <= rd_owner_d;
      rd_rr_q    <= rd_rr_d;
      wr_state_q <= wr_state_d;
      wr_owner_q <= wr_owner_d;
      wr_rr_q    <= wr_rr_d;
    end
  end

endmodule

// File: tb/tb_dma_mem_arbiter.sv
// Directed bench for dma_mem_arbiter: a round-robin instance and a fixed-priority
// instance share all inputs; the slave side is driven directly by each scenario.
module tb_dma_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] m_rd_req_addr, m_wr_req_addr, m_wr_data;
  logic [9:0]  m_rd_req_len, m_wr_req_len;
  logic [1:0]  m_rd_req_valid, m_rd_ready, m_wr_req_valid, m_wr_valid, m_wr_last;
  logic        s_rd_req_ready, s_rd_last, s_rd_valid, s_wr_req_ready, s_wr_ready;
  logic [31:0] s_rd_rdata;

  logic [1:0]  m_rd_req_ready, m_rd_valid, m_rd_last, m_wr_req_ready, m_wr_ready;
  logic [31:0] m_rd_rdata, s_rd_req_addr, s_wr_req_addr, s_wr_data;
  logic [4:0]  s_rd_req_len, s_wr_req_len;
  logic        s_rd_req_valid, s_rd_ready, s_wr_req_valid, s_wr_last, s_wr_valid;

  logic [1:0]  fp_m_rd_req_ready, fp_m_rd_valid, fp_m_rd_last, fp_m_wr_req_ready, fp_m_wr_ready;
  logic [31:0] fp_m_rd_rdata, fp_s_rd_req_addr, fp_s_wr_req_addr, fp_s_wr_data;
  logic [4:0]  fp_s_rd_req_len, fp_s_wr_req_len;
  logic        fp_s_rd_req_valid, fp_s_rd_ready, fp_s_wr_req_valid, fp_s_wr_last, fp_s_wr_valid;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  dma_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .FIXED_PRIO(0)) dut (
    .clk(clk), .rst(rst),
    .m_rd_req_addr(m_rd_req_addr), .m_rd_req_len(m_rd_req_len),
    .m_rd_req_valid(m_rd_req_valid), .m_rd_req_ready(m_rd_req_ready),
    .m_rd_rdata(m_rd_rdata), .m_rd_valid(m_rd_valid), .m_rd_last(m_rd_last),
    .m_rd_ready(m_rd_ready),
    .m_wr_req_addr(m_wr_req_addr), .m_wr_req_len(m_wr_req_len),
    .m_wr_req_valid(m_wr_req_valid), .m_wr_req_ready(m_wr_req_ready),
    .m_wr_data(m_wr_data), .m_wr_valid(m_wr_valid), .m_wr_last(m_wr_last),
    .m_wr_ready(m_wr_ready),
    .s_rd_req_addr(s_rd_req_addr), .s_rd_req_len(s_rd_req_len),
    .s_rd_req_valid(s_rd_req_valid), .s_rd_req_ready(s_rd_req_ready),
    .s_rd_rdata(s_rd_rdata), .s_rd_last(s_rd_last), .s_rd_valid(s_rd_valid),
    .s_rd_ready(s_rd_ready),
    .s_wr_req_addr(s_wr_req_addr), .s_wr_req_len(s_wr_req_len),
    .s_wr_req_valid(s_wr_req_valid), .s_wr_req_ready(s_wr_req_ready),
    .s_wr_data(s_wr_data), .s_wr_last(s_wr_last), .s_wr_valid(s_wr_valid),
    .s_wr_ready(s_wr_ready)
  );

  dma_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst(rst),
    .m_rd_req_addr(m_rd_req_addr), .m_rd_req_len(m_rd_req_len),
    .m_rd_req_valid(m_rd_req_valid), .m_rd_req_ready(fp_m_rd_req_ready),
    .m_rd_rdata(fp_m_rd_rdata), .m_rd_valid(fp_m_rd_valid), .m_rd_last(fp_m_rd_last),
    .m_rd_ready(m_rd_ready),
    .m_wr_req_addr(m_wr_req_addr), .m_wr_req_len(m_wr_req_len),
    .m_wr_req_valid(m_wr_req_valid), .m_wr_req_ready(fp_m_wr_req_ready),
    .m_wr_data(m_wr_data), .m_wr_valid(m_wr_valid), .m_wr_last(m_wr_last),
    .m_wr_ready(fp_m_wr_ready),
    .s_rd_req_addr(fp_s_rd_req_addr), .s_rd_req_len(fp_s_rd_req_len),
    .s_rd_req_valid(fp_s_rd_req_valid), .s_rd_req_ready(s_rd_req_ready),
    .s_rd_rdata(s_rd_rdata), .s_rd_last(s_rd_last), .s_rd_valid(s_rd_valid),
    .s_rd_ready(fp_s_rd_ready),
    .s_wr_req_addr(fp_s_wr_req_addr), .s_wr_req_len(fp_s_wr_req_len),
    .s_wr_req_valid(fp_s_wr_req_valid), .s_wr_req_ready(s_wr_req_ready),
    .s_wr_data(fp_s_wr_data), .s_wr_last(fp_s_wr_last), .s_wr_valid(fp_s_wr_valid),
    .s_wr_ready(s_wr_ready)
  );

  task automatic drive_idle();
    m_rd_req_addr = '0; m_rd_req_len = '0; m_rd_req_valid = '0; m_rd_ready = '0;
    m_wr_req_addr = '0; m_wr_req_len = '0; m_wr_req_valid = '0;
    m_wr_data = '0; m_wr_valid = '0; m_wr_last = '0;
    s_rd_req_ready = 0; s_rd_rdata = '0; s_rd_last = 0; s_rd_valid = 0;
    s_wr_req_ready = 0; s_wr_ready = 0;
  endtask

  // Inputs change at posedge+1, outputs are checked at posedge+2.
  task automatic do_reset();
    rst = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [13:0] ctl, fp_ctl;
    do_reset();
    #1;
    ctl = {m_rd_req_ready, m_rd_valid, m_rd_last, m_wr_req_ready, m_wr_ready,
           s_rd_req_valid, s_rd_ready, s_wr_req_valid, s_wr_last, s_wr_valid};
    fp_ctl = {fp_m_rd_req_ready, fp_m_rd_valid, fp_m_rd_last, fp_m_wr_req_ready, fp_m_wr_ready,
              fp_s_rd_req_valid, fp_s_rd_ready, fp_s_wr_req_valid, fp_s_wr_last, fp_s_wr_valid};
    vecs++;
    if (ctl !== 14'h0) begin
      errs++; $display("FAIL reset_ctl: got %h want 0", ctl);
    end
    vecs++;
    if (fp_ctl !== 14'h0) begin
      errs++; $display("FAIL reset_fp_ctl: got %h want 0", fp_ctl);
    end
  endtask

  task automatic test_idle_to_request();
    do_reset();
    m_rd_req_addr[63:32] = 32'h1000; m_rd_req_len[9:5] = 5'd7; m_rd_req_valid = 2'b10;
    #1;
    vecs++;
    if ({s_rd_req_valid, m_rd_req_ready} !== 3'b000) begin
      errs++; $display("FAIL idle_no_req: got %b want 000", {s_rd_req_valid, m_rd_req_ready});
    end
    @(posedge clk); #1;
    #1;
    vecs++;
    if ({s_rd_req_valid, s_rd_req_addr, s_rd_req_len, m_rd_req_ready} !==
        {1'b1, 32'h1000, 5'd7, 2'b00}) begin
      errs++; $display("FAIL req_fields: got %b %h %0d %b want 1 1000 7 00",
                       s_rd_req_valid, s_rd_req_addr, s_rd_req_len, m_rd_req_ready);
    end
    s_rd_req_ready = 1'b1;
    #1;
    vecs++;
    if (m_rd_req_ready !== 2'b10) begin
      errs++; $display("FAIL req_ready_owner: got %b want 10", m_rd_req_ready);
    end
    @(posedge clk); #1;
    m_rd_req_valid = 2'b00; s_rd_req_ready = 1'b0; m_rd_ready = 2'b11;
    for (int i = 0; i < 8; i++) begin
      s_rd_valid = 1'b1; s_rd_rdata = 32'h100 + i; s_rd_last = (i == 7);
      #1;
      vecs++;
      if ({m_rd_valid, m_rd_last, m_rd_rdata, s_rd_ready} !==
          {2'b10, (i == 7) ? 2'b10 : 2'b00, 32'h100 + i, 1'b1}) begin
        errs++; $display("FAIL rd_beat%0d: got v=%b l=%b d=%h r=%b", i,
                         m_rd_valid, m_rd_last, m_rd_rdata, s_rd_ready);
      end
      @(posedge clk); #1;
    end
    s_rd_last = 1'b0;
    #1;
    vecs++;
    if ({m_rd_valid, s_rd_ready} !== 3'b000) begin
      errs++; $display("FAIL rd_back_idle: got %b want 000", {m_rd_valid, s_rd_ready});
    end
    drive_idle();
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_rdy [12] = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00,
                                 2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00};
    logic [1:0] exp_val [12] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10,
                                 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10};
    do_reset();
    m_rd_req_addr = {32'h3000, 32'h2000}; m_rd_req_valid = 2'b11;
    s_rd_req_ready = 1; s_rd_valid = 1; s_rd_last = 1; m_rd_ready = 2'b11;
    for (int k = 0; k < 12; k++) begin
      #1;
      vecs++;
      if ({m_rd_req_ready, m_rd_valid} !== {exp_rdy[k], exp_val[k]}) begin
        errs++; $display("FAIL rr_cycle%0d: got rdy=%b val=%b want rdy=%b val=%b", k,
                         m_rd_req_ready, m_rd_valid, exp_rdy[k], exp_val[k]);
      end
      if (exp_rdy[k] != 2'b00) begin
        vecs++;
        if (s_rd_req_addr !== (exp_rdy[k][1] ? 32'h3000 : 32'h2000)) begin
          errs++; $display("FAIL rr_addr%0d: got %h", k, s_rd_req_addr);
        end
      end
      @(posedge clk); #1;
    end
    drive_idle();
  endtask

  task automatic test_fixed_priority();
    logic [1:0] exp_rdy [12] = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00,
                                 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00};
    logic [1:0] exp_val [12] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01,
                                 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01};
    do_reset();
    m_rd_req_addr = {32'h3000, 32'h2000}; m_rd_req_valid = 2'b11;
    s_rd_req_ready = 1; s_rd_valid = 1; s_rd_last = 1; m_rd_ready = 2'b11;
    for (int k = 0; k < 12; k++) begin
      #1;
      vecs++;
      if ({fp_m_rd_req_ready, fp_m_rd_valid} !== {exp_rdy[k], exp_val[k]}) begin
        errs++; $display("FAIL fp_cycle%0d: got rdy=%b val=%b want rdy=%b val=%b", k,
                         fp_m_rd_req_ready, fp_m_rd_valid, exp_rdy[k], exp_val[k]);
      end
      if (exp_rdy[k] != 2'b00) begin
        vecs++;
        if (fp_s_rd_req_addr !== 32'h2000) begin
          errs++; $display("FAIL fp_addr%0d: got %h want 2000", k, fp_s_rd_req_addr);
        end
      end
      @(posedge clk); #1;
    end
    drive_idle();
  endtask

  task automatic test_independent_channels();
    do_reset();
    m_wr_req_addr[31:0] = 32'h4000; m_wr_req_len[4:0] = 5'd3; m_wr_req_valid = 2'b01;
    m_rd_req_addr[63:32] = 32'h5000; m_rd_req_len[9:5] = 5'd0; m_rd_req_valid = 2'b10;
    s_wr_req_ready = 1; s_rd_req_ready = 1;
    @(posedge clk); #1;
    #1;
    vecs++;
    if ({s_wr_req_valid, s_wr_req_addr, s_wr_req_len, m_wr_req_ready} !==
        {1'b1, 32'h4000, 5'd3, 2'b01}) begin
      errs++; $display("FAIL wr_req: got %b %h %0d %b want 1 4000 3 01",
                       s_wr_req_valid, s_wr_req_addr, s_wr_req_len, m_wr_req_ready);
    end
    vecs++;
    if ({s_rd_req_valid, s_rd_req_addr, m_rd_req_ready} !== {1'b1, 32'h5000, 2'b10}) begin
      errs++; $display("FAIL rd_req_conc: got %b %h %b want 1 5000 10",
                       s_rd_req_valid, s_rd_req_addr, m_rd_req_ready);
    end
    @(posedge clk); #1;
    m_wr_req_valid = 0; m_rd_req_valid = 0; s_wr_req_ready = 0; s_rd_req_ready = 0;
    m_rd_ready = 2'b10; s_rd_valid = 1; s_rd_last = 1; s_rd_rdata = 32'h55; s_wr_ready = 1;
    for (int i = 0; i < 4; i++) begin
      m_wr_valid = 2'b01; m_wr_data[31:0] = 32'hA0 + i; m_wr_last = (i == 3) ? 2'b01 : 2'b00;
      #1;
      vecs++;
      if ({s_wr_data, s_wr_valid, s_wr_last, m_wr_ready} !==
          {32'hA0 + i, 1'b1, (i == 3), 2'b01}) begin
        errs++; $display("FAIL wr_beat%0d: got d=%h v=%b l=%b r=%b", i,
                         s_wr_data, s_wr_valid, s_wr_last, m_wr_ready);
      end
      if (i == 0) begin
        vecs++;
        if ({m_rd_valid, m_rd_last, m_rd_rdata, s_rd_ready} !== {2'b10, 2'b10, 32'h55, 1'b1})
        begin
          errs++; $display("FAIL rd_conc_beat: got v=%b l=%b d=%h r=%b",
                           m_rd_valid, m_rd_last, m_rd_rdata, s_rd_ready);
        end
      end
      @(posedge clk); #1;
      if (i == 0) s_rd_valid = 0;
    end
    m_wr_valid = 0; m_wr_last = 0; s_rd_valid = 1;
    #1;
    vecs++;
    if ({m_wr_ready, m_rd_valid} !== 4'b0000) begin
      errs++; $display("FAIL conc_back_idle: got %b want 0000", {m_wr_ready, m_rd_valid});
    end
    drive_idle();
  endtask

  task automatic test_backpressure();
    int b = 0;
    do_reset();
    m_wr_req_addr[63:32] = 32'h6000; m_wr_req_len[9:5] = 5'd7; m_wr_req_valid = 2'b10;
    s_wr_req_ready = 1;
    @(posedge clk); #1;
    #1;
    vecs++;
    if ({s_wr_req_len, s_wr_req_addr, m_wr_req_ready} !== {5'd7, 32'h6000, 2'b10}) begin
      errs++; $display("FAIL bp_req: got %0d %h %b want 7 6000 10",
                       s_wr_req_len, s_wr_req_addr, m_wr_req_ready);
    end
    @(posedge clk); #1;
    m_wr_req_valid = 0; s_wr_req_ready = 0;
    for (int c = 0; c < 40 && b < 8; c++) begin
      s_wr_ready = (c % 2 == 0);
      m_wr_valid = 2'b10; m_wr_data[63:32] = 32'hB0 + b; m_wr_last = (b == 7) ? 2'b10 : 2'b00;
      #1;
      vecs++;
      if ({m_wr_ready, s_wr_data, s_wr_valid, s_wr_last} !==
          {s_wr_ready ? 2'b10 : 2'b00, 32'hB0 + b, 1'b1, (b == 7)}) begin
        errs++; $display("FAIL bp_cycle%0d: got r=%b d=%h v=%b l=%b", c,
                         m_wr_ready, s_wr_data, s_wr_valid, s_wr_last);
      end
      if (s_wr_ready) b++;
      @(posedge clk); #1;
    end
    vecs++;
    if (b !== 8) begin
      errs++; $display("FAIL bp_beat_count: got %0d want 8", b);
    end
    m_wr_valid = 0; m_wr_last = 0; s_wr_ready = 1;
    #1;
    vecs++;
    if (m_wr_ready !== 2'b00) begin
      errs++; $display("FAIL bp_back_idle: got %b want 00", m_wr_ready);
    end
    drive_idle();
  endtask

  task automatic test_reset_mid_burst();
    logic [13:0] ctl;
    do_reset();
    m_rd_req_addr[31:0] = 32'h7000; m_rd_req_len[4:0] = 5'd7; m_rd_req_valid = 2'b01;
    s_rd_req_ready = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    m_rd_req_valid = 0; s_rd_req_ready = 0; m_rd_ready = 2'b01;
    for (int i = 0; i < 3; i++) begin
      s_rd_valid = 1; s_rd_rdata = 32'h70 + i;
      #1;
      vecs++;
      if (m_rd_valid !== 2'b01) begin
        errs++; $display("FAIL mid_beat%0d: got %b want 01", i, m_rd_valid);
      end
      @(posedge clk); #1;
    end
    s_rd_rdata = 32'h73; rst = 1;
    @(posedge clk); #1;
    s_rd_req_ready = 1; s_wr_ready = 1; s_wr_req_ready = 1;
    #1;
    ctl = {m_rd_req_ready, m_rd_valid, m_rd_last, m_wr_req_ready, m_wr_ready,
           s_rd_req_valid, s_rd_ready, s_wr_req_valid, s_wr_last, s_wr_valid};
    vecs++;
    if (ctl !== 14'h0) begin
      errs++; $display("FAIL mid_rst_outputs: got %h want 0", ctl);
    end
    rst = 0; s_rd_valid = 0; s_wr_ready = 0; s_wr_req_ready = 0;
    m_rd_req_addr[63:32] = 32'h8000; m_rd_req_len[9:5] = 5'd0; m_rd_req_valid = 2'b10;
    #1;
    vecs++;
    if (m_rd_req_ready !== 2'b00) begin
      errs++; $display("FAIL mid_rst_idle: got %b want 00", m_rd_req_ready);
    end
    @(posedge clk); #1;
    #1;
    vecs++;
    if ({m_rd_req_ready, s_rd_req_addr} !== {2'b10, 32'h8000}) begin
      errs++; $display("FAIL post_rst_grant: got %b %h want 10 8000",
                       m_rd_req_ready, s_rd_req_addr);
    end
    @(posedge clk); #1;
    m_rd_req_valid = 0; s_rd_req_ready = 0; m_rd_ready = 2'b10;
    s_rd_valid = 1; s_rd_last = 1;
    #1;
    vecs++;
    if ({m_rd_valid, m_rd_last} !== 4'b1010) begin
      errs++; $display("FAIL post_rst_beat: got %b want 1010", {m_rd_valid, m_rd_last});
    end
    @(posedge clk); #1;
    drive_idle();
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    test_reset();
    test_idle_to_request();
    test_round_robin();
    test_fixed_priority();
    test_independent_channels();
    test_backpressure();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
